// File: rtl/bfly_mul_ctrl_if.sv
// Bundle between the butterfly-multiplier controller and its upstream/downstream neighbours.
// Handshake: a beat moves only in a cycle where in_valid && in_ready; out_valid is a pure strobe with no back-pressure.
interface bfly_mul_ctrl_if #(
  parameter int NBLK   = 32,
  parameter int STAGES = 5,
  parameter int AW     = (NBLK > 1) ? $clog2(NBLK) : 1,
  parameter int SW     = (STAGES > 1) ? $clog2(STAGES) : 1
);
  logic          start;
  logic [SW-1:0] stage_sel;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] tw_addr;
  logic          tw_en;
  logic          out_valid;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          drop_err;
  logic [1:0]    state_dbg;

  modport master (
    output start, stage_sel, in_valid,
    input  in_ready, tw_addr, tw_en, out_valid, out_last, busy, done, drop_err, state_dbg
  );

  modport slave (
    input  start, stage_sel, in_valid,
    output in_ready, tw_addr, tw_en, out_valid, out_last, busy, done, drop_err, state_dbg
  );
endinterface

// File: rtl/bfly_mul_ctrl.sv
// Frame controller for the FFT butterfly multiplier: counts beats, generates twiddle
// addresses for the selected stage and tracks the ROM+multiply latency to flag output beats.
module bfly_mul_ctrl #(
  parameter int N      = 16,
  parameter int NBLK   = 32,
  parameter int STAGES = 5,
  parameter int LAT    = 2,
  parameter int AW     = $clog2(NBLK)
) (
  input  logic            clk,
  input  logic            rstn,
  bfly_mul_ctrl_if.slave  bus
);
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [AW-1:0] LAST_CNT  = AW'(NBLK - 1);
  localparam logic [SW-1:0] MAX_STAGE = SW'(STAGES - 1);

  if (N < 1) begin : g_bad_n
    $error("bfly_mul_ctrl: N must be at least 1");
  end
  if (NBLK < 2 || NBLK > 256 || (NBLK & (NBLK - 1)) != 0) begin : g_bad_nblk
    $error("bfly_mul_ctrl: NBLK must be a power of two in 2..256");
  end
  if (LAT < 1 || LAT > 8) begin : g_bad_lat
    $error("bfly_mul_ctrl: LAT must be in 1..8");
  end
  if (AW != $clog2(NBLK)) begin : g_bad_aw
    $error("bfly_mul_ctrl: AW must equal clog2(NBLK)");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  blk_cnt;
  logic [SW-1:0]  stage_q;
  logic [SW-1:0]  stage_sat;
  logic [LAT-1:0] vpipe, lpipe;
  logic           done_q, drop_q;
  logic           run, fire, last_beat, start_acc;
  logic           out_valid, out_last;

  assign run       = (state_q == RUN);
  assign fire      = bus.in_valid & run;
  assign last_beat = (blk_cnt == LAST_CNT);
  assign out_valid = vpipe[LAT-1];
  assign out_last  = lpipe[LAT-1];

  // Out-of-range stage requests clamp to the last stage so the stride never exceeds the frame.
  assign stage_sat = (int'(bus.stage_sel) >= STAGES) ? MAX_STAGE : bus.stage_sel;

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          start_acc = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (fire && last_beat) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blk_cnt <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      done_q <= (state_q == DRAIN) && out_last;
      if (start_acc) begin
        blk_cnt <= '0;
        stage_q <= stage_sat;
      end else if (fire) begin
        blk_cnt <= last_beat ? '0 : blk_cnt + AW'(1);
      end
      // A stray beat in the same cycle as the clearing start still leaves the flag set.
      drop_q <= (drop_q & ~start_acc) | (bus.in_valid & ~run);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vpipe <= '0;
      lpipe <= '0;
    end else begin
      vpipe[0] <= fire;
      lpipe[0] <= fire & last_beat;
      for (int i = 1; i < LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        lpipe[i] <= lpipe[i-1];
      end
    end
  end

  assign bus.in_ready  = run;
  assign bus.tw_en     = fire;
  assign bus.tw_addr   = run ? (blk_cnt << stage_q) : '0;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.drop_err  = drop_q;
  assign bus.state_dbg = state_q;

  a_last_has_valid : assert property (@(posedge clk) disable iff (!rstn) out_last |-> out_valid);
  a_no_ready_drain : assert property (@(posedge clk) disable iff (!rstn) (state_q != RUN) |-> !bus.tw_en);
endmodule

// File: tb/tb_bfly_mul_ctrl.sv
// Bench for bfly_mul_ctrl: frame-level vector table, directed corner sequences and random
// traffic, all compared against a queue-based model of the frame behaviour.
module tb_bfly_mul_ctrl;
  localparam int N      = 16;
  localparam int NBLK   = 32;
  localparam int STAGES = 5;
  localparam int LAT    = 2;
  localparam int AW     = $clog2(NBLK);
  localparam int SW     = $clog2(STAGES);

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  bfly_mul_ctrl_if #(.NBLK(NBLK), .STAGES(STAGES)) bus ();

  bfly_mul_ctrl #(.N(N), .NBLK(NBLK), .STAGES(STAGES), .LAT(LAT), .AW(AW)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model: a frame is a queue of the twiddle addresses still to be consumed.
  typedef struct { int t; bit last; } ev_t;
  logic [AW-1:0] exp_q[$];
  ev_t           m_outq[$];
  bit            m_busy;
  bit            m_drop;
  int            m_done_at;

  int s_ready, s_en, s_addr, s_ov, s_ol, s_busy, s_done, s_drop;

  typedef struct {
    int sel; bit toggle;
    int a1; int a9; int a31;
    int first_ov; int last_off; int done_off; int pulses;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy    = 1'b0;
    m_drop    = 1'b0;
    m_done_at = -1;
    exp_q.delete();
    m_outq.delete();
  endtask

  function automatic bit frame_open();
    return m_busy && (exp_q.size() > 0);
  endfunction

  // One clock cycle: drive, predict, sample at negedge, compare, then advance the model.
  task automatic tick(input bit rst, input bit st, input int sel, input bit iv);
    bit e_ready, e_fire, e_ov, e_ol, e_done, e_busy, e_drop, st_acc;
    int e_addr, stg;
    ev_t ev;
    rstn          = !rst;
    bus.start     = st;
    bus.stage_sel = SW'(sel);
    bus.in_valid  = iv;
    if (rst) model_reset();
    e_ready = frame_open();
    e_fire  = iv && e_ready;
    e_addr  = e_ready ? int'(exp_q[0]) : 0;
    e_ov    = (m_outq.size() > 0) && (m_outq[0].t == cyc);
    e_ol    = e_ov && m_outq[0].last;
    e_done  = (m_done_at == cyc);
    e_busy  = m_busy;
    e_drop  = m_drop;
    @(negedge clk);
    s_ready = int'(bus.in_ready);
    s_en    = int'(bus.tw_en);
    s_addr  = int'(bus.tw_addr);
    s_ov    = int'(bus.out_valid);
    s_ol    = int'(bus.out_last);
    s_busy  = int'(bus.busy);
    s_done  = int'(bus.done);
    s_drop  = int'(bus.drop_err);
    chk("in_ready",  s_ready, int'(e_ready));
    chk("tw_en",     s_en,    int'(e_fire));
    chk("tw_addr",   s_addr,  e_addr);
    chk("out_valid", s_ov,    int'(e_ov));
    chk("out_last",  s_ol,    int'(e_ol));
    chk("busy",      s_busy,  int'(e_busy));
    chk("done",      s_done,  int'(e_done));
    chk("drop_err",  s_drop,  int'(e_drop));
    if (!rst) begin
      st_acc = st && !m_busy;
      if (e_ov) void'(m_outq.pop_front());
      if (e_fire) begin
        ev.t    = cyc + LAT;
        ev.last = (exp_q.size() == 1);
        m_outq.push_back(ev);
        if (ev.last) m_done_at = cyc + LAT + 1;
        void'(exp_q.pop_front());
      end
      if (m_busy && (cyc + 1 == m_done_at)) m_busy = 1'b0;
      if (st_acc) begin
        stg    = ((sel % (1 << SW)) >= STAGES) ? STAGES - 1 : (sel % (1 << SW));
        m_busy = 1'b1;
        m_drop = 1'b0;
        exp_q.delete();
        for (int k = 0; k < NBLK; k++) exp_q.push_back(AW'((k * (1 << stg)) % NBLK));
      end
      if (iv && !e_ready) m_drop = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Feed the open frame continuously until the model says the frame has finished.
  task automatic run_out(input int limit);
    int n;
    n = 0;
    while (m_busy && n < limit) begin
      tick(1'b0, 1'b0, 0, frame_open());
      n++;
    end
    chk("frame_timeout", int'(n < limit), 1);
  endtask

  initial begin
    int off, nfire, npulse, first_ov, last_off, done_off, n;
    int a[NBLK];
    bit iv;

    rstn          = 1'b0;
    bus.start     = 1'b0;
    bus.stage_sel = '0;
    bus.in_valid  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 0, 1'b0);
    chk("rst_busy", s_busy, 0);
    chk("rst_addr", s_addr, 0);

    vecs[0] = '{0, 1'b0,  1,  9, 31, 3, 34, 35, NBLK};
    vecs[1] = '{2, 1'b0,  4,  4, 28, 3, 34, 35, NBLK};
    vecs[2] = '{1, 1'b1,  2, 18, 30, 3, 65, 66, NBLK};
    vecs[3] = '{3, 1'b0,  8,  8, 24, 3, 34, 35, NBLK};
    vecs[4] = '{7, 1'b0, 16, 16, 16, 3, 34, 35, NBLK};
    vecs[5] = '{4, 1'b1, 16, 16, 16, 3, 65, 66, NBLK};

    for (int v = 0; v < 6; v++) begin
      foreach (a[i]) a[i] = -1;
      tick(1'b0, 1'b1, vecs[v].sel, 1'b0);
      off = 1; nfire = 0; npulse = 0; first_ov = -1; last_off = -1; done_off = -1;
      while (done_off < 0 && off < 200) begin
        iv = frame_open() && (!vecs[v].toggle || (off % 2 == 1));
        tick(1'b0, 1'b0, 0, iv);
        if (s_en == 1) begin
          if (nfire < NBLK) a[nfire] = s_addr;
          nfire++;
        end
        if (s_ov == 1) begin
          npulse++;
          if (first_ov < 0) first_ov = off;
        end
        if (s_ol == 1) last_off = off;
        if (s_done == 1) done_off = off;
        off++;
      end
      chk("tbl_addr1",    a[1],     vecs[v].a1);
      chk("tbl_addr9",    a[9],     vecs[v].a9);
      chk("tbl_addr31",   a[31],    vecs[v].a31);
      chk("tbl_first_ov", first_ov, vecs[v].first_ov);
      chk("tbl_last_off", last_off, vecs[v].last_off);
      chk("tbl_done_off", done_off, vecs[v].done_off);
      chk("tbl_pulses",   npulse,   vecs[v].pulses);
    end

    // start together with a stray beat in IDLE
    tick(1'b0, 1'b1, 0, 1'b1);
    chk("idle_beat_no_en", s_en, 0);
    tick(1'b0, 1'b0, 0, 1'b0);
    chk("idle_beat_drop", s_drop, 1);
    chk("idle_beat_run", s_ready, 1);
    run_out(300);
    tick(1'b0, 1'b0, 0, 1'b0);

    // start during RUN is ignored; beat offered during DRAIN flags drop_err
    tick(1'b0, 1'b1, 2, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 0, 1'b1);
    tick(1'b0, 1'b1, 3, 1'b0);
    tick(1'b0, 1'b0, 0, 1'b1);
    chk("ign_start_addr", s_addr, 20);
    n = 0;
    while (frame_open() && n < 100) begin
      tick(1'b0, 1'b0, 0, 1'b1);
      n++;
    end
    tick(1'b0, 1'b0, 0, 1'b1);
    chk("drain_no_en", s_en, 0);
    tick(1'b0, 1'b0, 0, 1'b0);
    chk("drain_drop", s_drop, 1);
    run_out(300);
    tick(1'b0, 1'b0, 0, 1'b0);
    tick(1'b0, 1'b0, 0, 1'b0);
    chk("drop_sticky", s_drop, 1);
    tick(1'b0, 1'b1, 0, 1'b0);
    tick(1'b0, 1'b0, 0, 1'b0);
    chk("drop_cleared", s_drop, 0);
    run_out(300);
    tick(1'b0, 1'b0, 0, 1'b0);

    // reset after 10 accepted beats aborts the frame
    tick(1'b0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 0, 1'b1);
    tick(1'b1, 1'b0, 0, 1'b1);
    chk("midrst_ready", s_ready, 0);
    chk("midrst_ov", s_ov, 0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 0, 1'b0);
    tick(1'b0, 1'b1, 0, 1'b0);
    tick(1'b0, 1'b0, 0, 1'b1);
    chk("postrst_en", s_en, 1);
    chk("postrst_addr", s_addr, 0);

    // back-to-back: new start in the done cycle
    n = 0;
    while (m_done_at != cyc && n < 300) begin
      tick(1'b0, 1'b0, 0, frame_open());
      n++;
    end
    tick(1'b0, 1'b1, 1, 1'b0);
    chk("b2b_done", s_done, 1);
    tick(1'b0, 1'b0, 0, 1'b1);
    chk("b2b_en", s_en, 1);
    chk("b2b_addr0", s_addr, 0);
    tick(1'b0, 1'b0, 0, 1'b1);
    chk("b2b_addr1", s_addr, 2);
    tick(1'b0, 1'b0, 0, 1'b1);
    chk("b2b_addr2", s_addr, 4);
    run_out(300);
    tick(1'b0, 1'b0, 0, 1'b0);

    // random traffic: bursty valids, start spam, random stage, rare resets
    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
           int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 80; i++) tick(1'b0, 1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
